rggen_riscv_csrbus_requester: RTL

//  Core-side master of riscv_csrbus_if, directly upstream of the RgGen CSR-bus adapter.

---
 rtl/rggen_riscv_csrbus_requester_if.sv | 23 ++
 rtl/rggen_riscv_csrbus_requester.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rggen_riscv_csrbus_requester_if.sv
// riscv_csrbus_if: CSR bus between the core-side requester (master) and the RgGen adapter (slave)
//  valid, csr, funct3, rs1, rs1_value : master -> slave
//  ready, rd_value, error             : slave  -> master
interface riscv_csrbus_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [11:0]     csr;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [XLEN-1:0] rs1_value;
    logic            ready;
    logic [XLEN-1:0] rd_value;
    logic            error;
    modport master (
        output valid, csr, funct3, rs1, rs1_value,
        input  ready, rd_value, error
    );
    modport slave (
        input  valid, csr, funct3, rs1, rs1_value,
        output ready, rd_value, error
    );
endinterface

// File: rtl/rggen_riscv_csrbus_requester.sv
// rggen_riscv_csrbus_requester: one-outstanding Zicsr requester driving riscv_csrbus_if
//  i_clk, i_rst            clock, asynchronous active-high reset
//  i_req_*                 decoded Zicsr request from execute (valid/ready handshake)
//  o_rsp_*, i_rsp_ready    response to writeback (rd echo, old CSR value, error)
//  csrbus_if               master side of the CSR bus
//  Optional bus-wait timeout: define RGGEN_RISCV_CSRBUS_TIMEOUT_EN
module rggen_riscv_csrbus_requester #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [11:0]     i_req_csr,
    input  logic [4:0]      i_req_rs1,
    input  logic [XLEN-1:0] i_req_rs1_value,
    input  logic [4:0]      i_req_rd,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [4:0]      o_rsp_rd,
    output logic [XLEN-1:0] o_rsp_rd_value,
    output logic            o_rsp_error,
    riscv_csrbus_if.master  csrbus_if
);
    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t          state;
    state_t          state_d;
    logic [2:0]      h_funct3;
    logic [11:0]     h_csr;
    logic [4:0]      h_rs1;
    logic [XLEN-1:0] h_rs1_value;
    logic [4:0]      h_rd;
    logic            bus_timeout;
    logic            legal;
    logic            accept;

    // funct3 000 and 100 are not Zicsr encodings
    assign legal  = i_req_funct3[1:0] != 2'b00;
    assign accept = state == IDLE && i_req_valid;

`ifdef RGGEN_RISCV_CSRBUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    // ready on the expiry cycle still wins
    assign bus_timeout = state == BUS && !csrbus_if.ready && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            wait_cnt <= '0;
        else
            wait_cnt <= (state == BUS && !csrbus_if.ready) ? wait_cnt + 1'b1 : '0;
    end
`else
    assign bus_timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state;
        o_req_ready     = 1'b0;
        o_rsp_valid     = 1'b0;
        csrbus_if.valid = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    state_d = legal ? BUS : RSP;
            end
            BUS: begin
                csrbus_if.valid = 1'b1;
                if (csrbus_if.ready || bus_timeout)
                    state_d = RSP;
            end
            RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            h_funct3       <= '0;
            h_csr          <= '0;
            h_rs1          <= '0;
            h_rs1_value    <= '0;
            h_rd           <= '0;
            o_rsp_rd_value <= '0;
            o_rsp_error    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                h_funct3       <= i_req_funct3;
                h_csr          <= i_req_csr;
                h_rs1          <= i_req_rs1;
                h_rs1_value    <= i_req_rs1_value;
                h_rd           <= i_req_rd;
                o_rsp_rd_value <= '0;
                o_rsp_error    <= !legal;
            end
            if (state == BUS && csrbus_if.ready) begin
                o_rsp_rd_value <= csrbus_if.rd_value;
                o_rsp_error    <= csrbus_if.error;
            end else if (bus_timeout) begin
                o_rsp_rd_value <= '0;
                o_rsp_error    <= 1'b1;
            end
        end
    end

    assign csrbus_if.csr       = h_csr;
    assign csrbus_if.funct3    = h_funct3;
    assign csrbus_if.rs1       = h_rs1;
    assign csrbus_if.rs1_value = h_rs1_value;
    assign o_rsp_rd            = h_rd;
endmodule
